crc_word_reader: RTL
====================

# crc_word_reader

Sequencing stage that sits directly in front of the byte-lane word RAM (`ram_mem_sim`, 1-cycle registered read). On a `start` command it streams a contiguous block of 32-bit words out of the RAM, folds each word into a CRC-32 (IEEE 802.3, reflected) at one word per cycle, and reports the final checksum with a one-cycle `done` pulse. It is the address and read-enable master for the RAM read port; write enables on that RAM are owned elsewhere and are not driven by this block.

## Interface
- `SIZE`, 12: RAM byte-address width; word address is `SIZE-2` bits and must match the RAM instance.
- `clk`  in  1  rising-edge clock shared with the RAM.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  SIZE-2  first word address; sampled with `start`.
- `len`  in  SIZE-1  word count, 0 to 2^(SIZE-2); sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `crc` valid from this cycle.
- `crc`  out  32  final CRC; holds until the next accepted `start`.
- `mem_ren`  out  1  RAM read enable (registered).
- `mem_addr`  out  SIZE-2  RAM word address (registered).
- `mem_dout`  in  32  RAM read data; valid the cycle after `mem_ren`.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `start`=1 latches `base_addr`/`len`, sets CRC state to 0xFFFFFFFF. If `len`=0 -> DONE; else -> READ, drives `mem_ren`=1, `mem_addr`=`base_addr`.
- READ: issues one read per cycle, `mem_addr` incrementing by 1 modulo 2^(SIZE-2); wrap past the top address is allowed and silent. After the `len`-th address is issued -> DRAIN and `mem_ren`=0.
- Data-valid tag: a 1-bit register delayed from `mem_ren`. When it is set, `mem_dout` is folded into the CRC state.
- DRAIN: folds the last word -> DONE.
- DONE: `crc` <= ~state, `done`=1 for one cycle, `busy`=0 -> IDLE.
- CRC fold: reflected polynomial 0xEDB88320. Process the 32 word bits LSB first, bit 0 through bit 31 in one combinational step. This equals the byte stream byte0 = `[7:0]` (lane a) first, then `[15:8]`, `[23:16]`, `[31:24]`.
- `start` while not IDLE is ignored. It is not queued.
- `len` above 2^(SIZE-2) is illegal. The block still reads exactly `len` words, wrapping the address.

## Timing
- Reset values: `busy`=0, `done`=0, `crc`=0, `mem_ren`=0, `mem_addr`=0, state IDLE, tag 0.
- Let edge E0 sample `start`=1 with `len`=N≥1. Then:
  - After E0 through after E(N-1): `mem_ren`=1, `mem_addr`=base+k.
  - After E(N+1): `done`=1 and `crc` valid.
  - Latency from start to done is N+1 cycles.
  - `busy` is 1 from after E0 through after E(N+1) inclusive, then 0 when `done` drops.
  - Throughput: one word per cycle, no bubbles.
- For `len`=0: `done`=1 and `crc`=0x00000000 after E0. No `mem_ren` is issued.
- `done` and `start` on the same cycle: `start` is ignored, because the block is not in IDLE. A new `start` is accepted on the cycle after `done`.
- Reset mid-operation: all outputs return to reset values immediately. There is no `done` pulse, and an in-flight RAM read is discarded.
- `mem_dout` is only sampled when the tag is set. RAM output in other cycles is don't-care.

## Test plan
- Reset, then `start`, base=0, len=1, word[0]=0x34333231 ("1234") -> `mem_ren` high exactly 1 cycle at addr 0; `done` 2 cycles after start; `crc`=0x9BE3E0A3.
- len=1, word=0x00000000 -> `crc`=0x2144DF1C. Same with word=0xFFFFFFFF -> `crc`=0xFFFFFFFF.
- len=0 -> `done` next cycle, `crc`=0x00000000, `mem_ren` never asserted.
- SIZE=12, base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles. `crc` matches a software model over those four words.
- `start` pulsed every cycle during a len=8 run -> exactly one `done`. The second run starts only after `done`, and `crc` holds between runs.
- Assert `rst` in the middle of a len=16 run -> all outputs 0 immediately. A subsequent len=1 run gives the correct CRC.

Source files
------------

// File: rtl/crc_word_reader_if.sv
// Command, status and RAM read-port signals of crc_word_reader.
// The master drives commands and RAM read data; the slave is the reader itself.
interface crc_word_reader_if #(
   parameter int unsigned SIZE = 12
);
   logic              start;
   logic [SIZE-3:0]   base_addr;
   logic [SIZE-2:0]   len;
   logic              busy;
   logic              done;
   logic [31:0]       crc;
   logic              mem_ren;
   logic [SIZE-3:0]   mem_addr;
   logic [31:0]       mem_dout;

   modport master (
      output start, base_addr, len, mem_dout,
      input  busy, done, crc, mem_ren, mem_addr
   );

   modport slave (
      input  start, base_addr, len, mem_dout,
      output busy, done, crc, mem_ren, mem_addr
   );
endinterface

// File: rtl/crc_word_reader.sv
// Streams a block of 32-bit words from a 1-cycle-latency RAM and folds each
// one into a reflected CRC-32, one word per cycle, then pulses done.
module crc_word_reader #(
   parameter int unsigned SIZE = 12
) (
   input logic               clk,
   input logic               rst,
   crc_word_reader_if.slave  bus
);
   localparam int unsigned AW = SIZE - 2;
   localparam int unsigned LW = SIZE - 1;
   localparam logic [31:0] Poly = 32'hEDB88320;

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            ren_q, ren_d;
   logic [LW-1:0]   remain_q, remain_d;
   logic            tag_q;
   logic [31:0]     lfsr_q, lfsr_d;
   logic [31:0]     crc_q, crc_d;
   logic [31:0]     folded;

   // Whole word LSB first, which matches feeding byte lanes 0..3 in order.
   function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [31:0] w);
      logic [31:0] r;
      r = c ^ w;
      for (int i = 0; i < 32; i++) begin
         r = r[0] ? ((r >> 1) ^ Poly) : (r >> 1);
      end
      return r;
   endfunction

   // Next-state: sequencing FSM, read address generation and CRC accumulation.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      ren_d    = ren_q;
      remain_d = remain_q;
      lfsr_d   = lfsr_q;
      crc_d    = crc_q;
      folded   = crc_fold(lfsr_q, bus.mem_dout);
      // tag marks the cycle the RAM presents data for an issued read
      if (tag_q) begin
         lfsr_d = folded;
      end
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               lfsr_d = '1;
               if (bus.len == '0) begin
                  crc_d   = '0;
                  state_d = StDone;
               end else begin
                  ren_d    = 1'b1;
                  addr_d   = bus.base_addr;
                  remain_d = bus.len;
                  state_d  = StRead;
               end
            end
         end
         StRead: begin
            if (remain_q == LW'(1)) begin
               ren_d   = 1'b0;
               state_d = StDrain;
            end else begin
               addr_d   = addr_q + AW'(1);
               remain_d = remain_q - LW'(1);
            end
         end
         StDrain: begin
            crc_d   = ~folded;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; reset aborts any run and discards in-flight read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         ren_q    <= 1'b0;
         remain_q <= '0;
         tag_q    <= 1'b0;
         lfsr_q   <= '0;
         crc_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         ren_q    <= ren_d;
         remain_q <= remain_d;
         tag_q    <= ren_q;
         lfsr_q   <= lfsr_d;
         crc_q    <= crc_d;
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StDone);
   assign bus.crc      = crc_q;
   assign bus.mem_ren  = ren_q;
   assign bus.mem_addr = addr_q;
endmodule
